// File: rtl/dpram_arbiter.sv
// rtl/dpram_arbiter.sv - round-robin dual-grant arbiter in front of a dual-port RAM
module dpram_arbiter #(
    parameter int N_REQ = 4,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [N_REQ*DW-1:0] rdata,
    output logic                ram_w1,
    output logic                ram_w2,
    output logic [AW-1:0]       ram_addr1,
    output logic [AW-1:0]       ram_addr2,
    output logic [DW-1:0]       ram_d1,
    output logic [DW-1:0]       ram_d2,
    input  logic [DW-1:0]       ram_dout1,
    input  logic [DW-1:0]       ram_dout2
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] a_idx;
    logic [PW-1:0] b_idx;
    logic          a_vld;
    logic          b_vld;
    logic          a_go;
    logic          b_go;

    logic          tag1_v;
    logic          tag2_v;
    logic [PW-1:0] tag1_i;
    logic [PW-1:0] tag2_i;

    // Pick winner A scanning from ptr, then winner B scanning past A while
    // skipping candidates that would collide with A on the same address.
    always_comb begin
        logic [PW-1:0] cand;
        logic          clash;
        a_vld = 1'b0;
        a_idx = '0;
        b_vld = 1'b0;
        b_idx = '0;
        cand  = '0;
        clash = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + PW'(k);
            if (!a_vld && req[cand]) begin
                a_vld = 1'b1;
                a_idx = cand;
            end
        end
        for (int k = 1; k < N_REQ; k++) begin
            cand  = a_idx + PW'(k);
            clash = (addr[cand*AW +: AW] == addr[a_idx*AW +: AW]) &&
                    (we[a_idx] || we[cand]);
            if (a_vld && !b_vld && req[cand] && !clash) begin
                b_vld = 1'b1;
                b_idx = cand;
            end
        end
    end

    // Grants are suppressed for as long as reset is held.
    assign a_go = a_vld && !rst;
    assign b_go = b_vld && !rst;

    // Drive grants and both RAM ports from the two winners; idle ports read as zero.
    always_comb begin
        gnt       = '0;
        ram_w1    = 1'b0;
        ram_addr1 = '0;
        ram_d1    = '0;
        ram_w2    = 1'b0;
        ram_addr2 = '0;
        ram_d2    = '0;
        if (a_go) begin
            gnt[a_idx] = 1'b1;
            ram_w1     = we[a_idx] && req[a_idx];
            ram_addr1  = addr[a_idx*AW +: AW];
            ram_d1     = wdata[a_idx*DW +: DW];
        end
        if (b_go) begin
            gnt[b_idx] = 1'b1;
            ram_w2     = we[b_idx] && req[b_idx];
            ram_addr2  = addr[b_idx*AW +: AW];
            ram_d2     = wdata[b_idx*DW +: DW];
        end
    end

    // Advance the round-robin pointer just past the last requester served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (b_go) begin
            ptr <= b_idx + 1'b1;
        end else if (a_go) begin
            ptr <= a_idx + 1'b1;
        end
    end

    // Remember which requester owns each port's read while the RAM fetches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag1_v <= 1'b0;
            tag1_i <= '0;
            tag2_v <= 1'b0;
            tag2_i <= '0;
        end else begin
            tag1_v <= a_go && !we[a_idx];
            tag1_i <= a_idx;
            tag2_v <= b_go && !we[b_idx];
            tag2_i <= b_idx;
        end
    end

    // Route returning RAM data to the owning requester with a one-cycle valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= '0;
            if (tag1_v) begin
                rvalid[tag1_i]          <= 1'b1;
                rdata[tag1_i*DW +: DW]  <= ram_dout1;
            end
            if (tag2_v) begin
                rvalid[tag2_i]          <= 1'b1;
                rdata[tag2_i*DW +: DW]  <= ram_dout2;
            end
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// tb/tb_dpram_arbiter.sv - directed scoreboard bench for dpram_arbiter
module tb_dpram_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [7:0]  a [4];
    logic [7:0]  d [4];
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [31:0] rdata;
    logic        ram_w1, ram_w2;
    logic [7:0]  ram_addr1, ram_addr2, ram_d1, ram_d2;
    logic [7:0]  ram_dout1, ram_dout2;

    logic [7:0]  mem [256];
    logic [7:0]  exp_mem [256];

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         due;
    } sb_t;
    sb_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit done    = 0;
    int obs_cnt [4];

    assign addr  = {a[3], a[2], a[1], a[0]};
    assign wdata = {d[3], d[2], d[1], d[0]};

    dpram_arbiter #(.N_REQ(4), .AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_w1    (ram_w1),
        .ram_w2    (ram_w2),
        .ram_addr1 (ram_addr1),
        .ram_addr2 (ram_addr2),
        .ram_d1    (ram_d1),
        .ram_d2    (ram_d2),
        .ram_dout1 (ram_dout1),
        .ram_dout2 (ram_dout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Dual-port RAM with registered read data, cleared while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            ram_dout1 <= 8'h00;
            ram_dout2 <= 8'h00;
        end else begin
            if (ram_w1) mem[ram_addr1] <= ram_d1;
            if (ram_w2) mem[ram_addr2] <= ram_d2;
            ram_dout1 <= mem[ram_addr1];
            ram_dout2 <= mem[ram_addr2];
        end
    end

    // Read-return checker: every cycle rvalid must equal the set of reads due now.
    always @(negedge clk) begin
        logic [3:0]  exp_rv;
        logic [31:0] exp_rd;
        if (!done) begin
            exp_rv = 4'b0000;
            exp_rd = 32'h0;
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due == cyc) begin
                    exp_rv[sb[k].idx]          = 1'b1;
                    exp_rd[sb[k].idx*8 +: 8]   = sb[k].data;
                    sb.delete(k);
                end
            end
            n_tests++;
            assert (rvalid === exp_rv) else begin
                n_fail++;
                $error("FAIL rvalid cyc=%0d observed=%b expected=%b", cyc, rvalid, exp_rv);
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_rv[i]) begin
                    n_tests++;
                    assert (rdata[i*8 +: 8] === exp_rd[i*8 +: 8]) else begin
                        n_fail++;
                        $error("FAIL rdata[%0d] cyc=%0d observed=%h expected=%h",
                               i, cyc, rdata[i*8 +: 8], exp_rd[i*8 +: 8]);
                    end
                end
            end
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        req = 4'b0000;
        we  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            a[i] = 8'h00;
            d[i] = 8'h00;
        end
    endtask

    task automatic set_rd(input int i, input logic [7:0] ad);
        req[i] = 1'b1;
        we[i]  = 1'b0;
        a[i]   = ad;
        d[i]   = 8'h00;
    endtask

    task automatic set_wr(input int i, input logic [7:0] ad, input logic [7:0] dt);
        req[i] = 1'b1;
        we[i]  = 1'b1;
        a[i]   = ad;
        d[i]   = dt;
    endtask

    // Check the expected grant, then book expected read data and shadow writes.
    task automatic step(input logic [3:0] eg, input string tag);
        @(negedge clk);
        chk({28'h0, gnt}, {28'h0, eg}, tag);
        for (int i = 0; i < 4; i++) begin
            obs_cnt[i] += int'(gnt[i]);
            if (eg[i] && !we[i]) sb.push_back('{idx: i, data: exp_mem[a[i]], due: cyc + 2});
        end
        for (int i = 0; i < 4; i++)
            if (eg[i] && we[i]) exp_mem[a[i]] = d[i];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) obs_cnt[i] = 0;
        rst = 1'b1;
        clear();

        // Reset state
        tick();
        tick();
        step(4'b0000, "reset_gnt");
        chk({31'h0, ram_w1}, 32'h0, "reset_w1");
        chk({31'h0, ram_w2}, 32'h0, "reset_w2");
        chk(rdata, 32'h0, "reset_rdata");
        tick();
        rst = 1'b0;

        // Reset while a read is in flight: it must never return
        set_rd(0, 8'h10);
        step(4'b0001, "rstmid_gnt");
        tick();
        rst = 1'b1;
        sb.delete();
        step(4'b0000, "rstmid_hold1");
        chk({31'h0, ram_w1}, 32'h0, "rstmid_w1");
        tick();
        step(4'b0000, "rstmid_hold2");
        tick();
        clear();
        set_wr(3, 8'h99, 8'h77);
        rst = 1'b0;
        step(4'b1000, "post_rst_gnt");
        tick();
        clear();

        // Single write then read back
        set_wr(0, 8'h10, 8'hA5);
        step(4'b0001, "wr_gnt");
        chk({31'h0, ram_w1}, 32'h1, "wr_w1");
        chk({24'h0, ram_addr1}, 32'h10, "wr_addr1");
        chk({24'h0, ram_d1}, 32'hA5, "wr_d1");
        tick();
        clear();
        step(4'b0000, "idle0");
        tick();
        set_rd(0, 8'h10);
        step(4'b0001, "rd_gnt");
        chk({31'h0, ram_w1}, 32'h0, "rd_w1");
        tick();
        clear();
        step(4'b0000, "rd_wait1");
        tick();
        step(4'b0000, "rd_wait2");
        tick();

        // Preload for the dual grant, then steer ptr back to 0
        set_wr(0, 8'h03, 8'h11);
        set_wr(2, 8'h07, 8'h22);
        step(4'b0101, "preload_gnt");
        tick();
        clear();
        set_wr(3, 8'h99, 8'h33);
        step(4'b1000, "steer0_gnt");
        tick();
        clear();

        // Dual grant of two reads
        set_rd(0, 8'h03);
        set_rd(2, 8'h07);
        step(4'b0101, "dual_gnt");
        chk({24'h0, ram_addr1}, 32'h03, "dual_addr1");
        chk({24'h0, ram_addr2}, 32'h07, "dual_addr2");
        chk({30'h0, ram_w2, ram_w1}, 32'h0, "dual_we");
        tick();
        clear();

        // ptr must now be 3: requester 3 lands on port 1
        set_rd(3, 8'h50);
        set_rd(0, 8'h51);
        step(4'b1001, "ptr3_gnt");
        chk({24'h0, ram_addr1}, 32'h50, "ptr3_addr1");
        chk({24'h0, ram_addr2}, 32'h51, "ptr3_addr2");
        tick();
        clear();
        set_wr(3, 8'h99, 8'h44);
        step(4'b1000, "steer1_gnt");
        tick();
        clear();

        // Write/write collision: req1 must wait a cycle
        set_wr(0, 8'h20, 8'h01);
        set_wr(1, 8'h20, 8'h02);
        set_rd(2, 8'h30);
        step(4'b0101, "coll1_gnt");
        chk({24'h0, ram_addr2}, 32'h30, "coll1_addr2");
        tick();
        req[0] = 1'b0;
        req[2] = 1'b0;
        step(4'b0010, "coll2_gnt");
        chk({31'h0, ram_w1}, 32'h1, "coll2_w1");
        chk({24'h0, ram_d1}, 32'h02, "coll2_d1");
        tick();
        clear();
        set_rd(0, 8'h20);
        step(4'b0001, "coll_rd_gnt");
        tick();
        clear();

        // Read/read at the same address is granted together
        set_wr(1, 8'h40, 8'h5A);
        step(4'b0010, "rr_pre_gnt");
        tick();
        clear();
        set_rd(1, 8'h40);
        set_rd(3, 8'h40);
        step(4'b1010, "rr_gnt");
        chk({24'h0, ram_addr1}, 32'h40, "rr_addr1");
        chk({24'h0, ram_addr2}, 32'h40, "rr_addr2");
        tick();
        clear();
        set_wr(3, 8'h99, 8'h55);
        step(4'b1000, "steer2_gnt");
        tick();
        clear();

        // Fairness: everyone requesting continuously
        for (int i = 0; i < 4; i++) obs_cnt[i] = 0;
        for (int i = 0; i < 4; i++) set_rd(i, 8'h60 + 8'(i));
        for (int c = 0; c < 8; c++) begin
            step((c % 2 == 0) ? 4'b0011 : 4'b1100, "fair_gnt");
            tick();
        end
        clear();
        for (int i = 0; i < 4; i++) chk(obs_cnt[i], 32'd4, "fair_count");

        // Drain outstanding reads
        for (int c = 0; c < 3; c++) begin
            step(4'b0000, "drain");
            tick();
        end
        chk(sb.size(), 32'd0, "sb_empty");

        done = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
